// File: rtl/mp3_alias_pkg.sv
// mp3_alias_pkg: coefficient tables, FSM state type and boundary-count helper shared by the alias reducer.
package mp3_alias_pkg;
  localparam int LINES_PER_SB = 18;
  localparam int NUM_BFLY = 8;
  localparam int CW = 20;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam logic [NUM_BFLY-1:0][CW-1:0] CS = {
    20'd524283, 20'd524235, 20'd523848, 20'd521938,
    20'd515540, 20'd497879, 20'd462287, 20'd449573
  };
  // Bit patterns of negative Q1.19 values.
  localparam logic [NUM_BFLY-1:0][CW-1:0] CA = {
    20'd1046636, 20'd1041132, 20'd1027098, 20'd998992,
    20'd953201,  20'd884276,  20'd801253,  20'd778832
  };
  function automatic logic [4:0] bound_count(logic split, logic sw, logic [1:0] bt, logic [5:0] sb);
    logic [5:0] lim;
    lim = sb > 6'd32 ? 6'd32 : sb;
    if (split && bt == 2'd2) return (sw && sb >= 6'd2) ? 5'd1 : 5'd0;
    return lim == 6'd0 ? 5'd0 : 5'(lim - 6'd1);
  endfunction
endpackage

// File: rtl/alias_round_sat.sv
// alias_round_sat: rounds a scaled product field to DW bits and forms the saturating/wrapping butterfly sum.
module alias_round_sat #(
  parameter int DW = 20,
  parameter bit SAT = 1'b1
) (
  input  logic [DW:0]   fld,
  output logic [DW-1:0] rnd,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  output logic [DW-1:0] res
);
  localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
  logic [DW:0] sum;
  always_comb begin
    rnd = fld[DW:1] + {{(DW-1){1'b0}}, fld[0]};
    sum = sub ? {a[DW-1], a} - {b[DW-1], b} : {a[DW-1], a} + {b[DW-1], b};
    res = (SAT && sum[DW] != sum[DW-1]) ? (sum[DW] ? MINV : MAXV) : sum[DW-1:0];
  end
endmodule

// File: rtl/alias_reducer.sv
// alias_reducer: in-place layer-III anti-alias butterflies over one channel's granule RAM,
// sharing an external registered multiplier.
module alias_reducer
  import mp3_alias_pkg::*;
#(
  parameter int DW = 20,
  parameter int NCH = 2,
  parameter int AW = 13,
  parameter int REGION = 1,
  parameter bit SAT = 1'b1,
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1,
  localparam int RW = AW - CHW - 10
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  input  logic [CHW-1:0]   Channel,
  input  logic             Blocksplit_flag,
  input  logic             Switch_point,
  input  logic [1:0]       Block_type,
  input  logic [5:0]       Sb_limit,
  output logic [DW-1:0]    Mulin1,
  output logic [19:0]      Mulin2,
  input  logic [DW+19:0]   Mulout,
  output logic             Ram_CEN,
  output logic             Ram_WEN,
  output logic [AW-1:0]    Ram_A,
  output logic [DW-1:0]    Ram_D,
  input  logic [DW-1:0]    Ram_Q
);
  localparam logic [RW-1:0] REG_F = RW'(REGION);
  state_t state_q, state_d;
  logic [2:0] p_q, p_d, i_q, i_d;
  logic [4:0] b_q, b_d, n_q, n_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [DW-1:0] lo_q, lo_d, hi_q, hi_d, r0_q, r0_d, r1_q, r1_d, d_q, d_d;
  logic [DW-1:0] rnd, res;
  logic cen_q, cen_d, wen_q, wen_d;
  logic [AW-1:0] a_q, a_d;
  logic [9:0] base, lo_idx, hi_idx;
  logic run, act, unused_mul;

  assign unused_mul = ^{Mulout[DW+19], Mulout[17:0]};

  // r0 holds lo*cs then lo*ca, r1 holds hi*ca then hi*cs; p5 subtracts, p7 adds.
  alias_round_sat #(.DW(DW), .SAT(SAT)) u_rs (
    .fld(Mulout[DW+18:18]),
    .rnd(rnd),
    .a(r0_q),
    .b(r1_q),
    .sub(p_q == 3'd5),
    .res(res)
  );

  assign run = state_q == RUN;
  assign act = run && p_q >= 3'd2 && p_q <= 3'd5;
  assign Busy = state_q != IDLE;
  assign Done = state_q == DONE;
  assign Ram_CEN = cen_q;
  assign Ram_WEN = wen_q;
  assign Ram_A = a_q;
  assign Ram_D = d_q;
  assign Mulin1 = !act ? '0 : p_q < 3'd4 ? Ram_Q : p_q == 3'd4 ? lo_q : hi_q;
  assign Mulin2 = !act ? '0 : (p_q == 3'd2 || p_q == 3'd5) ? CS[i_q] : CA[i_q];

  always_comb begin
    state_d = state_q;
    p_d = p_q;
    i_d = i_q;
    b_d = b_q;
    n_d = n_q;
    ch_d = ch_q;
    lo_d = lo_q;
    hi_d = hi_q;
    r0_d = r0_q;
    r1_d = r1_q;
    cen_d = 1'b1;
    wen_d = 1'b1;
    a_d = '0;
    d_d = '0;
    base = 10'(b_q) * 10'd18;
    lo_idx = base + 10'd17 - 10'(i_q);
    hi_idx = base + 10'd18 + 10'(i_q);
    case (state_q)
      IDLE: if (Start) begin
        n_d = bound_count(Blocksplit_flag, Switch_point, Block_type, Sb_limit);
        ch_d = Channel;
        p_d = '0;
        i_d = '0;
        b_d = '0;
        state_d = n_d != 5'd0 ? RUN : FLUSH;
      end
      RUN: begin
        p_d = p_q + 3'd1;
        i_d = p_q == 3'd7 ? i_q + 3'd1 : i_q;
        b_d = (p_q == 3'd7 && i_q == 3'd7) ? b_q + 5'd1 : b_q;
        if (p_q == 3'd7 && i_q == 3'd7 && b_q == n_q - 5'd1) state_d = FLUSH;
        cen_d = !(p_q == 3'd0 || p_q == 3'd1 || p_q == 3'd5 || p_q == 3'd7);
        wen_d = !(p_q == 3'd5 || p_q == 3'd7);
        a_d = cen_d ? '0 : {REG_F, ch_q, (p_q == 3'd0 || p_q == 3'd5) ? lo_idx : hi_idx};
        d_d = wen_d ? '0 : res;
        lo_d = p_q == 3'd2 ? Ram_Q : lo_q;
        hi_d = p_q == 3'd3 ? Ram_Q : hi_q;
        r0_d = (p_q == 3'd3 || p_q == 3'd5) ? rnd : r0_q;
        r1_d = (p_q == 3'd4 || p_q == 3'd6) ? rnd : r1_q;
      end
      FLUSH: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state_q <= IDLE;
      p_q <= '0;
      i_q <= '0;
      b_q <= '0;
      n_q <= '0;
      ch_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      r0_q <= '0;
      r1_q <= '0;
      cen_q <= 1'b1;
      wen_q <= 1'b1;
      a_q <= '0;
      d_q <= '0;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
      i_q <= i_d;
      b_q <= b_d;
      n_q <= n_d;
      ch_q <= ch_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      r0_q <= r0_d;
      r1_q <= r1_d;
      cen_q <= cen_d;
      wen_q <= wen_d;
      a_q <= a_d;
      d_q <= d_d;
    end
endmodule
